seq_bit_serializer: RTL and testbench

Parallel-to-serial front end for the sequence-detector path. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `bit_out`, which drives the detector's serial input `x`. A one-word holding register lets back-to-back words stream with no idle bit between them. A programmable idle gap can be inserted between words instead.

---
 rtl/seq_bit_serializer.sv | 197 +++++++++++++++++++
 tb/tb_seq_bit_serializer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out on bit_out.
// Latency: accept at edge E0 from IDLE drives bit 0 in the cycle after E0; bit k follows edge E0+k.
// Backpressure: one-word holding register; in_ready drops while it is full, no idle bit between words when GAP=0.
//
// Build option: define SER_LSB_FIRST_EN for LSB-first bit order (default MSB first).
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   in_data      word to serialize, sampled on accept (in_valid && in_ready)
//   in_valid     in_data is valid
//   in_ready     block can take a word: !rst && !hold_full
//   bit_out      registered serial bit, 0 whenever bit_valid is 0
//   bit_valid    bit_out carries a data bit this cycle
//   frame_start  pulse with the first bit of each word
//   word_done    pulse with the last bit of each word
//   busy         shifting, in the inter-word gap, or holding a word

module seq_bit_serializer #(
  parameter int WIDTH = 8,   // bits per word, 2..32
  parameter int GAP   = 0    // idle cycles after each word, 0..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);
  localparam logic [3:0]    GAP_INIT   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  // Position of the bit that goes out first; the shift register always
  // keeps the bit currently on the wire at this position.
`ifdef SER_LSB_FIRST_EN
  localparam int LEAD = 0;
`else
  localparam int LEAD = WIDTH - 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             word_done_q, word_done_d;

  logic             accept;
  logic             have_next;
  logic             load_word;
  logic             hold_write;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] shifted;

  assign in_ready = !rst && !hold_full_q;
  assign accept   = in_valid && in_ready;

  // A word is ready to follow the current one either from the holding
  // register or straight off the input when an accept lands exactly on the
  // word boundary with the hold empty (bypass keeps streams contiguous).
  assign have_next = hold_full_q || accept;
  assign next_word = hold_full_q ? hold_q : in_data;

`ifdef SER_LSB_FIRST_EN
  assign shifted = {1'b0, sreg_q[WIDTH-1:1]};
`else
  assign shifted = {sreg_q[WIDTH-2:0], 1'b0};
`endif

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    gcnt_d        = gcnt_q;
    bit_out_d     = 1'b0;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    word_done_d   = 1'b0;
    load_word     = 1'b0;
    hold_write    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Hold is always empty here, so an accept goes straight to sreg.
        if (accept) begin
          load_word = 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_q != LAST_IDX) begin
          cnt_d       = cnt_q + 1'b1;
          sreg_d      = shifted;
          bit_out_d   = shifted[LEAD];
          bit_valid_d = 1'b1;
          word_done_d = (cnt_q == PENULT_IDX);
          hold_write  = accept;
        end else if (GAP == 0) begin
          if (have_next) begin
            load_word = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d    = S_GAP;
          gcnt_d     = GAP_INIT;
          hold_write = accept;
        end
      end

      S_GAP: begin
        if (gcnt_q == 4'd0) begin
          if (have_next) begin
            load_word = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gcnt_d     = gcnt_q - 4'd1;
          hold_write = accept;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (hold_write) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    // Start a new word: bit 0 goes on the wire at this same edge.
    if (load_word) begin
      state_d       = S_SHIFT;
      sreg_d        = next_word;
      cnt_d         = '0;
      hold_full_d   = 1'b0;
      bit_out_d     = next_word[LEAD];
      bit_valid_d   = 1'b1;
      frame_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sreg_q        <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      gcnt_q        <= 4'd0;
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      word_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      gcnt_q        <= gcnt_d;
      bit_out_q     <= bit_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      word_done_q   <= word_done_d;
    end
  end

  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign word_done   = word_done_q;
  assign busy        = (state_q != S_IDLE) || hold_full_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
module tb_seq_bit_serializer;

  localparam int W = 8;
  localparam int MAXW = 4096;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] in_data     [2];
  logic         in_valid    [2];
  logic         in_ready    [2];
  logic         bit_out     [2];
  logic         bit_valid   [2];
  logic         frame_start [2];
  logic         word_done   [2];
  logic         busy        [2];

  seq_bit_serializer #(.WIDTH(W), .GAP(0)) u_ser0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .bit_out(bit_out[0]), .bit_valid(bit_valid[0]),
    .frame_start(frame_start[0]), .word_done(word_done[0]), .busy(busy[0]));

  seq_bit_serializer #(.WIDTH(W), .GAP(2)) u_ser1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .bit_out(bit_out[1]), .bit_valid(bit_valid[1]),
    .frame_start(frame_start[1]), .word_done(word_done[1]), .busy(busy[1]));

  // Reference model: each accepted word gets a start cycle; its bits occupy
  // cycles start..start+W-1 and the next word may start W+GAP cycles later.
  logic [W-1:0] mw [2][MAXW];
  int           ms [2][MAXW];
  int           nw [2];
  int           base [2];
  int           last_end [2];
  int           e;
  int           n_chk;
  int           n_fail;

  logic         acc_flag [2];
  int           acc_edge [2];
  logic [31:0]  cap  [2];
  int           ncap [2];
  int           nbusy [2];

  function automatic int gap_of(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  function automatic logic model_bit(input logic [W-1:0] w, input int k);
    logic [W-1:0] t;
    t = w;
`ifdef SER_LSB_FIRST_EN
    return t[k];
`else
    return t[W-1-k];
`endif
  endfunction

  function automatic int find_word(input int d, input int c);
    for (int i = nw[d] - 1; i >= base[d] && i >= nw[d] - 4; i--)
      if (ms[d][i] <= c && c < ms[d][i] + W) return i;
    return -1;
  endfunction

  function automatic logic pending(input int d, input int c);
    if (nw[d] > base[d] && ms[d][nw[d]-1] > c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", name, d, e, act, exp);
    end
  endtask

  // One clock: drive inputs, check in_ready, update model at the edge, then
  // compare every output against the model in the following cycle.
  task automatic step(input logic r, input logic v0, input logic [W-1:0] d0,
                      input logic v1, input logic [W-1:0] d1);
    logic mr [2];
    int   s;
    int   i;
    int   k;
    logic eb, ev, ef, ed, ebz;
    rst         = r;
    in_valid[0] = v0;
    in_data[0]  = d0;
    in_valid[1] = v1;
    in_data[1]  = d1;
    #1;
    for (int d = 0; d < 2; d++) begin
      mr[d] = !r && !pending(d, e);
      check("in_ready", d, 32'(in_ready[d]), 32'(mr[d]));
      acc_flag[d] = in_valid[d] && mr[d];
    end
    @(posedge clk);
    e++;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        base[d]     = nw[d];
        last_end[d] = -1000;
      end else if (acc_flag[d]) begin
        s = (e > last_end[d]) ? e : last_end[d];
        mw[d][nw[d]] = in_data[d];
        ms[d][nw[d]] = s;
        nw[d]++;
        last_end[d] = s + W + gap_of(d);
        acc_edge[d] = e;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      i = find_word(d, e);
      if (i >= 0) begin
        k  = e - ms[d][i];
        eb = model_bit(mw[d][i], k);
        ev = 1'b1;
        ef = (k == 0);
        ed = (k == W - 1);
      end else begin
        eb = 1'b0; ev = 1'b0; ef = 1'b0; ed = 1'b0;
      end
      ebz = (e < last_end[d]);
      check("bit_out",     d, 32'(bit_out[d]),     32'(eb));
      check("bit_valid",   d, 32'(bit_valid[d]),   32'(ev));
      check("frame_start", d, 32'(frame_start[d]), 32'(ef));
      check("word_done",   d, 32'(word_done[d]),   32'(ed));
      check("busy",        d, 32'(busy[d]),        32'(ebz));
      if (bit_valid[d] === 1'b1) begin
        cap[d] = {cap[d][30:0], bit_out[d]};
        ncap[d]++;
      end
      if (busy[d] === 1'b1) nbusy[d]++;
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic clear_cap();
    for (int d = 0; d < 2; d++) begin
      cap[d]   = '0;
      ncap[d]  = 0;
      nbusy[d] = 0;
    end
  endtask

  // Hold in_valid high with one word on DUT d until it is accepted (bounded).
  task automatic offer(input int d, input logic [W-1:0] w);
    int n;
    n = 0;
    acc_flag[d] = 1'b0;
    while (!acc_flag[d] && n < 50) begin
      if (d == 0) step(1'b0, 1'b1, w, 1'b0, '0);
      else        step(1'b0, 1'b0, '0, 1'b1, w);
      n++;
    end
    if (!acc_flag[d]) check("accept_timeout", d, 32'(n), 32'(0));
  endtask

  function automatic int hits1010(input logic [15:0] s);
    int h;
    h = 0;
    for (int i = 0; i <= 12; i++)
      if (s[15-i -: 4] == 4'b1010) h++;
    return h;
  endfunction

  int ea;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      in_data[d]  = '0;
      nw[d]       = 0;
      base[d]     = 0;
      last_end[d] = -1000;
      acc_flag[d] = 1'b0;
      acc_edge[d] = 0;
    end
    e      = -1;
    n_chk  = 0;
    n_fail = 0;
    clear_cap();
    @(negedge clk);

    // Reset: all outputs low, in_ready low while rst is high.
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 8'h11, 1'b1, 8'h22);
    idle(2);

    // Single word 8'hA5.
    clear_cap();
    offer(0, 8'hA5);
    idle(10);
    check("a5_stream", 0, cap[0] & 32'hFF, 32'h0000_00A5);
    check("a5_count",  0, 32'(ncap[0]), 32'd8);

    // Back-to-back 8'h5A, 8'hA5 with in_valid held.
    clear_cap();
    offer(0, 8'h5A);
    offer(0, 8'hA5);
    idle(20);
    check("b2b_stream", 0, cap[0] & 32'hFFFF, 32'h0000_5AA5);
    check("b2b_count",  0, 32'(ncap[0]), 32'd16);
    check("b2b_hits",   0, 32'(hits1010(cap[0][15:0])), 32'd3);

    // GAP=2 instance: FF then 00, two idle bits between, busy throughout.
    clear_cap();
    offer(1, 8'hFF);
    offer(1, 8'h00);
    idle(25);
    check("gap_stream", 1, cap[1] & 32'hFFFF, 32'h0000_FF00);
    check("gap_count",  1, 32'(ncap[1]), 32'd16);
    check("gap_busy",   1, 32'(nbusy[1]), 32'd20);

    // Backpressure: three words offered continuously.
    clear_cap();
    offer(0, 8'h81);
    ea = acc_edge[0];
    offer(0, 8'h42);
    offer(0, 8'h24);
    check("third_accept_delay", 0, 32'(acc_edge[0] - ea), 32'd9);
    idle(30);
    check("bp_stream", 0, cap[0] & 32'hFF_FFFF, 32'h0081_4224);
    check("bp_count",  0, 32'(ncap[0]), 32'd24);

    // Reset during bit 3 of 8'hC3 with a second word held.
    clear_cap();
    offer(0, 8'hC3);
    offer(0, 8'h99);
    idle(2);
    check("pre_reset_bits", 0, 32'(ncap[0]), 32'd4);
    clear_cap();
    step(1'b1, 1'b0, '0, 1'b0, '0);
    idle(15);
    check("post_reset_bits", 0, 32'(ncap[0]), 32'd0);
    offer(0, 8'h3C);
    idle(12);
    check("after_reset_stream", 0, cap[0] & 32'hFF, 32'h0000_003C);

    // Bit order on a non-palindromic word.
    clear_cap();
    offer(0, 8'h0A);
    idle(12);
`ifdef SER_LSB_FIRST_EN
    check("order_0a", 0, cap[0] & 32'hFF, 32'h0000_0050);
`else
    check("order_0a", 0, cap[0] & 32'hFF, 32'h0000_000A);
`endif

    // Randomized traffic on both instances, occasional reset.
    for (int j = 0; j < 2000; j++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 2) != 0), W'($urandom),
           ($urandom_range(0, 3) != 0), W'($urandom));
    end
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
